// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: one instruction through fetch/decode/execute/mem/writeback.
// Define MEM_WAIT_EN to let mem_ready stall FETCH, MEMRD and MEMWR; otherwise mem_ready is ignored.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       NEqual,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       Jal,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state_o,
    output logic       instr_done,
    output logic       illegal
);

    // state  | meaning
    // IDLE   | post-reset bubble
    // FETCH  | read instruction, PC += 4 on ready
    // DECODE | read registers, precompute branch target
    // MEMADR | effective address for lw/sw
    // MEMRD  | data read
    // MEMWB  | load writeback
    // MEMWR  | data write
    // EXEC   | R-type ALU op
    // ALUWB  | R-type writeback
    // ADDIEX | addi ALU op
    // ADDIWB | addi writeback
    // BRANCH | beq/bne compare and conditional PC load
    // JUMP   | j
    // JAL    | jal, link to $31
    // JR     | jr
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14
    } state_t;

    state_t state_q, state_d;
    logic   rdy;

`ifdef MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign state_o = state_q;

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        NEqual      = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        Jal         = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = rdy;
                PCWrite = rdy;
                ALUSrcB = 2'b01;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    6'b000000: state_d = (funct == 6'b001000) ? S_JR : S_EXEC;
                    6'b001000: state_d = S_ADDIEX;
                    6'b100011,
                    6'b101011: state_d = S_MEMADR;
                    6'b000100,
                    6'b000101: state_d = S_BRANCH;
                    6'b000010: state_d = S_JUMP;
                    6'b000011: state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // opcode[3] separates sw (101011) from lw (100011)
                state_d = opcode[3] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = rdy;
                if (rdy) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                NEqual      = opcode[0];
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                RegWrite   = 1'b1;
                Jal        = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            // code 15 behaves as IDLE
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded directed bench for multicycle_control: per-cycle expected state/control words are
// queued by the stimulus and popped by a negedge monitor.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, NEqual, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, Jal, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_o;
    logic       instr_done, illegal;

    int n_total = 0;
    int n_pass  = 0;
    logic [23:0] exp_q[$];

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .NEqual(NEqual), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .Jal(Jal), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state_o(state_o),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [23:0] dut_word;
    assign dut_word = {state_o, PCWrite, PCWriteCond, NEqual, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, Jal, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                       instr_done, illegal};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected control word for a state, straight from the state/output table.
    function automatic logic [23:0] exp_out(input logic [3:0] st, input logic rdy_in,
                                            input logic neq, input logic ill);
        logic pcw, pcwc, ne, iord, mr, mw, irw, m2r, rdst, rw, jl, srca, done, illo, rdy;
        logic [1:0] srcb, aluop, pcs;
`ifdef MEM_WAIT_EN
        rdy = rdy_in;
`else
        rdy = 1'b1;
`endif
        {pcw, pcwc, ne, iord, mr, mw, irw, m2r, rdst, rw, jl, srca, done, illo} = '0;
        srcb = 2'b00; aluop = 2'b00; pcs = 2'b00;
        case (st)
            4'd1:  begin mr = 1; irw = rdy; pcw = rdy; srcb = 2'b01; end
            4'd2:  begin srcb = 2'b11; illo = ill; end
            4'd3:  begin srca = 1; srcb = 2'b10; end
            4'd4:  begin mr = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; done = 1; end
            4'd6:  begin mw = 1; iord = 1; done = rdy; end
            4'd7:  begin srca = 1; aluop = 2'b10; end
            4'd8:  begin rw = 1; rdst = 1; done = 1; end
            4'd9:  begin srca = 1; srcb = 2'b10; end
            4'd10: begin rw = 1; done = 1; end
            4'd11: begin srca = 1; aluop = 2'b01; pcwc = 1; pcs = 2'b01; ne = neq; done = 1; end
            4'd12: begin pcw = 1; pcs = 2'b10; done = 1; end
            4'd13: begin pcw = 1; pcs = 2'b10; rw = 1; jl = 1; done = 1; end
            4'd14: begin pcw = 1; pcs = 2'b11; done = 1; end
            default: ;
        endcase
        return {st, pcw, pcwc, ne, iord, mr, mw, irw, m2r, rdst, rw, jl, srca, srcb, aluop, pcs,
                done, illo};
    endfunction

    // One clock of stimulus: drive mem_ready, queue the expected word for this cycle, advance.
    task automatic step(input logic [3:0] st, input logic rdy, input logic neq, input logic ill);
        mem_ready = rdy;
        exp_q.push_back(exp_out(st, rdy, neq, ill));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [23:0] e;
            e = exp_q.pop_front();
            chk($sformatf("cycle_state%0d", e[23:20]), {8'h0, dut_word}, {8'h0, e});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0;
        #2;
        chk("reset_outputs", {8'h0, dut_word}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'd0, 1, 0, 0);

        // add
        opcode = 6'b000000; funct = 6'b100000;
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd7, 1, 0, 0); step(4'd8, 1, 0, 0);

        // lw
        opcode = 6'b100011; funct = 6'd0;
`ifdef MEM_WAIT_EN
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd3, 1, 0, 0);
        step(4'd4, 0, 0, 0); step(4'd4, 0, 0, 0); step(4'd4, 1, 0, 0); step(4'd5, 1, 0, 0);
        // fetch stall: one idle cycle, single IRWrite/PCWrite in ready cycle
        opcode = 6'b001000;
        step(4'd1, 0, 0, 0); step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0);
        step(4'd9, 1, 0, 0); step(4'd10, 1, 0, 0);
`else
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd3, 1, 0, 0);
        step(4'd4, 1, 0, 0); step(4'd5, 1, 0, 0);
        // mem_ready ignored: sw still 4 cycles
        opcode = 6'b101011;
        step(4'd1, 0, 0, 0); step(4'd2, 0, 0, 0); step(4'd3, 0, 0, 0); step(4'd6, 0, 0, 0);
        opcode = 6'b001000;
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd9, 1, 0, 0); step(4'd10, 1, 0, 0);
`endif

        // bne, beq
        opcode = 6'b000101;
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd11, 1, 1, 0);
        opcode = 6'b000100;
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd11, 1, 0, 0);

        // jal then jr
        opcode = 6'b000011;
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd13, 1, 0, 0);
        opcode = 6'b000000; funct = 6'b001000;
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd14, 1, 0, 0);

        // illegal opcode
        opcode = 6'b111111; funct = 6'd0;
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 1);

        // sw with reset asserted during MEMWR
        opcode = 6'b101011;
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd3, 1, 0, 0);
        mem_ready = 1'b0;
        #1;
        chk("memwr_live", {27'h0, state_o, MemWrite}, {27'h0, 4'd6, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("reset_in_memwr", {8'h0, dut_word}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'd0, 1, 0, 0);

        // j after reset recovery
        opcode = 6'b000010;
        step(4'd1, 1, 0, 0); step(4'd2, 1, 0, 0); step(4'd12, 1, 0, 0);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS datapath. It steps one instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It drives the shared-ALU/shared-memory datapath control lines per state and stalls on a memory ready handshake. It sits beside the register file, ALU and unified instruction/data memory, and decodes `opcode`/`funct` from the instruction register.

## Interface
- No parameters; encodings are fixed below.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  6  IR[31:26], stable from DECODE until the next FETCH.
- `funct`  in  6  IR[5:0].
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load if the branch condition holds.
- `NEqual`  out  1  branch condition select: 1 = bne, 0 = beq.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  instruction register load.
- `MemtoReg`  out  1  register write data select: 1 = MDR, 0 = ALUOut.
- `RegDst`  out  1  register write destination select: 1 = rd, 0 = rt.
- `RegWrite`  out  1  register file write.
- `Jal`  out  1  write PC+4 to $31 (overrides RegDst/MemtoReg).
- `ALUSrcA`  out  1  ALU operand A: 0 = PC, 1 = A register.
- `ALUSrcB`  out  2  ALU operand B: 00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate<<2.
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = use funct.
- `PCSource`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs.
- `state_o`  out  4  current state code.
- `instr_done`  out  1  one-cycle pulse in the last cycle of a retiring instruction.
- `illegal`  out  1  one-cycle pulse on an unknown opcode.

## Operation
- Supported opcodes: R = 000000, addi = 001000, lw = 100011, sw = 101011, beq = 000100, bne = 000101, j = 000010, jal = 000011.
- jr is opcode 000000 with funct 001000.
- Any output not listed for a state is 0.
- Outputs are decoded from the state register. `IRWrite` and the FETCH `PCWrite` are additionally qualified by `mem_ready`.
- States, as code: asserted outputs → next state.
  - 0 IDLE: none → FETCH.
  - 1 FETCH: MemRead, IRWrite&ready, PCWrite&ready, ALUSrcB=01 → DECODE when ready, else stay.
  - 2 DECODE: ALUSrcB=11. Next state by instruction:
    - lw/sw → MEMADR.
    - jr → JR.
    - other R → EXEC.
    - addi → ADDIEX.
    - beq/bne → BRANCH.
    - j → JUMP.
    - jal → JAL.
    - otherwise `illegal`=1 → FETCH.
  - 3 MEMADR: ALUSrcA, ALUSrcB=10 → MEMRD (lw) or MEMWR (sw).
  - 4 MEMRD: MemRead, IorD → MEMWB when ready.
  - 5 MEMWB: RegWrite, MemtoReg → FETCH.
  - 6 MEMWR: MemWrite, IorD → FETCH when ready.
  - 7 EXEC: ALUSrcA, ALUOp=10 → ALUWB.
  - 8 ALUWB: RegWrite, RegDst → FETCH.
  - 9 ADDIEX: ALUSrcA, ALUSrcB=10 → ADDIWB.
  - 10 ADDIWB: RegWrite → FETCH.
  - 11 BRANCH: ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01, NEqual=opcode[0] → FETCH.
  - 12 JUMP: PCWrite, PCSource=10 → FETCH.
  - 13 JAL: PCWrite, PCSource=10, RegWrite, Jal → FETCH.
  - 14 JR: PCWrite, PCSource=11 → FETCH.
- Code 15 is unreachable and decodes to IDLE.
- `instr_done` asserts in MEMWB, MEMWR&ready, ALUWB, ADDIWB, BRANCH, JUMP, JAL and JR.
- `instr_done` is never asserted together with `illegal`.

## Timing
- Zero-wait cycle counts:
  - j, jal, jr, beq, bne: 3 cycles.
  - R, addi, sw: 4 cycles.
  - lw: 5 cycles.
- Each idle `mem_ready` cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Strobes and selects stay constant while stalled.
- `IRWrite`/`PCWrite` fire exactly once per fetch, in the ready cycle.
- Reset:
  - `rst_n` low forces IDLE immediately.
  - All outputs are 0 and `state_o` = 0.
  - An in-flight access (including MemWrite) drops in the same cycle.
- The first FETCH is in the second rising edge after reset release.
- `mem_ready` is ignored outside memory states.

## Configuration
- `MEM_WAIT_EN` defined:
  - `mem_ready` gates FETCH, MEMRD and MEMWR as described above.
- `MEM_WAIT_EN` undefined:
  - `mem_ready` is ignored and treated as 1.
  - Every memory state lasts exactly one cycle.
  - The port remains present.

## Test plan
- Reset then add (opcode 000000, funct 100000), `mem_ready`=1 → `state_o` 0,1,2,7,8,1; RegWrite=RegDst=1 only in state 8; `instr_done` in state 8.
- lw with `mem_ready` low for 2 cycles in MEMRD → states 1,2,3,4,4,4,5,1; MemRead=IorD=1 throughout state 4; 7 cycles total.
- bne (000101) → BRANCH with PCWriteCond=1, NEqual=1, ALUOp=01, PCSource=01; beq gives NEqual=0.
- jal then jr (000000/001000) → JAL: PCWrite=RegWrite=Jal=1, PCSource=10; JR: PCWrite=1, PCSource=11, RegWrite=0.
- Opcode 111111 → `illegal` pulse in DECODE, next state FETCH, no `instr_done`.
- sw stalled in MEMWR, `rst_n` pulsed low → MemWrite drops combinationally, `state_o`=0; with `MEM_WAIT_EN` undefined, `mem_ready`=0 still gives a 4-cycle sw.
